rca_adder: RTL and testbench
============================

RCA_ADDER -- requirements
Module: rca_adder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port enable, input, 1, reset: asynchronous, active-low (enable=0 clears all state; enable=1 runs).
REQ-004 SHALL have port in_sum_a, input, DATA_WIDTH, unsigned operand A.
REQ-005 SHALL have port in_sum_b, input, DATA_WIDTH, unsigned operand B.
REQ-006 SHALL have port out_sum_result, output, DATA_WIDTH, registered sum bits [DATA_WIDTH-1:0].
REQ-007 SHALL have port out_carry, output, 1, registered carry-out of MSB.
REQ-008 SHALL have one clock (clk) and one reset (enable), with the reset asynchronous and active-low; no other control ports.

Function
REQ-009 SHALL register in_sum_a and in_sum_b into input registers on every rising clk while enable=1.
REQ-010 SHALL compute {carry,sum} = A_reg + B_reg combinationally as a ripple-carry chain of DATA_WIDTH one-bit full adders; carry-in to bit 0 is 0.
REQ-011 SHALL register the chain result into out_sum_result/out_carry on the next rising clk.
REQ-012 SHALL have latency exactly 2 rising edges from input sample to output valid; throughput one new operand pair per cycle.
REQ-013 SHALL treat operands as unsigned; overflow wraps modulo 2^DATA_WIDTH with out_carry=1.
REQ-014 SHALL give bit i of sum = a_i XOR b_i XOR c_i, with c_(i+1) = a_i&b_i | c_i&(a_i XOR b_i).
REQ-015 SHALL hold outputs stable between edges; outputs change only on rising clk or on reset assertion.
REQ-016 SHALL have no valid/handshake; every cycle is a valid sample.

Reset
REQ-017 SHALL, on enable falling to 0, immediately (without clk) clear input registers, out_sum_result to 0 and out_carry to 0.
REQ-018 SHALL hold all registers at 0 while enable=0, regardless of inputs or clk.
REQ-019 SHALL, after enable rises, sample inputs at the first rising clk and present their sum at the second.
REQ-020 SHALL discard any in-flight operation when reset asserts mid-operation.

Structure
REQ-021 SHALL keep DATA_WIDTH as a module parameter; no shared package required.
REQ-022 SHALL use one sub-module, full_adder (inputs a, b, cin; outputs s, cout), instantiated DATA_WIDTH times via generate loop.
REQ-023 SHALL contain no behavioural "+" operator in the datapath; the carry chain is explicit.

Verification
REQ-024 Reset: enable=0 with in_sum_a=in_sum_b=0xFFFFFFFF -> out_sum_result=0, out_carry=0, with no clk edge required.
REQ-025 Basic: a=0x00000005, b=0x00000003 -> two edges later out_sum_result=0x00000008, out_carry=0.
REQ-026 Full ripple: a=0xFFFFFFFF, b=0x00000001 -> out_sum_result=0x00000000, out_carry=1.
REQ-027 Max: a=0xFFFFFFFF, b=0xFFFFFFFF -> out_sum_result=0xFFFFFFFE, out_carry=1.
REQ-028 Pipelining: back-to-back pairs (1,2),(3,4),(0x80000000,0x80000000) -> consecutive outputs 3/0, 7/0, 0/1.
REQ-029 Random: 10 random operand pairs, each held 2 cycles -> outputs match a golden (a+b) 33-bit model; also reset asserted mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/rca_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_adder_pkg;

  // Operand width used when the instantiating design does not override it.
  localparam int RCA_DEFAULT_WIDTH = 32;

  // Widest operand the adder is intended to be built with.
  localparam int RCA_MAX_WIDTH = 64;

  // Carry injected into bit 0 of the chain; the adder is a plain A+B.
  localparam logic RCA_CARRY_IN = 1'b0;

endpackage : rca_adder_pkg

// File: rtl/rca_adder_full_adder.sv
// One-bit full adder cell; the ripple chain in rca_adder is built from these.
module full_adder
  import rca_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  // Sum is the parity of the three inputs; carry propagates when a^b is set.
  always_comb begin
    w_half = a ^ b;
    s      = w_half ^ cin;
    cout   = (a & b) | (cin & w_half);
  end

endmodule : full_adder

// File: rtl/rca_adder.sv
// Two-stage registered ripple-carry adder: operands are captured on one edge,
// rippled through a chain of full adders, and the result is captured on the
// following edge. "enable" low acts as an asynchronous clear of every register.
module rca_adder
  import rca_adder_pkg::*;
#(
  parameter int DATA_WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_sum_a,
  input  logic [DATA_WIDTH-1:0] in_sum_b,
  output logic [DATA_WIDTH-1:0] out_sum_result,
  output logic                  out_carry
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH:0]   w_carry;

  assign w_carry[0] = RCA_CARRY_IN;

  // Explicit carry chain: bit i consumes the carry produced by bit i-1.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_chain
    full_adder u_fa (
      .a    (r_a[gi]),
      .b    (r_b[gi]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  // Operand capture stage; cleared immediately when enable drops.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= in_sum_a;
      r_b <= in_sum_b;
    end
  end

  // Result stage holds the rippled sum and final carry until the next edge.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      out_sum_result <= '0;
      out_carry      <= 1'b0;
    end else begin
      out_sum_result <= w_sum;
      out_carry      <= w_carry[DATA_WIDTH];
    end
  end

endmodule : rca_adder

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: a golden 33-bit arithmetic model with a
// two-edge delay is compared on every falling edge, and directed vectors are
// pinned against hand-computed literals.
module tb_rca_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         enable;
  logic [W-1:0] inSumA;
  logic [W-1:0] inSumB;
  logic [W-1:0] outSumResult;
  logic         outCarry;

  int errors = 0;
  int checks = 0;

  logic [W:0] modelPending = '0;
  logic [W:0] modelOut     = '0;
  bit         compareOn    = 1'b0;

  rca_adder #(.DATA_WIDTH(W)) dut (
    .clk            (clk),
    .enable         (enable),
    .in_sum_a       (inSumA),
    .in_sum_b       (inSumB),
    .out_sum_result (outSumResult),
    .out_carry      (outCarry)
  );

  // Free-running clock, period 10, first rising edge at t=5.
  always #5 clk = ~clk;

  // Golden model: the sum of a sampled pair appears one edge after sampling.
  always @(posedge clk or negedge enable) begin
    if (!enable) begin
      modelPending = '0;
      modelOut     = '0;
    end else begin
      modelOut     = modelPending;
      modelPending = {1'b0, inSumA} + {1'b0, inSumB};
    end
  end

  // Continuous comparison of the DUT against the model away from rising edges.
  always @(negedge clk) begin
    if (compareOn) begin
      checks++;
      if ({outCarry, outSumResult} !== modelOut) begin
        errors++;
        $display("[TB] FAIL model_cmp t=%0t: got sum=%h carry=%b, expected sum=%h carry=%b",
                 $time, outSumResult, outCarry, modelOut[W-1:0], modelOut[W]);
      end
    end
  end

  // Drive one operand pair just after a falling edge so it is stable at posedge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    #1;
    inSumA = a;
    inSumB = b;
  endtask

  // Advance n falling edges, landing just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Compare the DUT outputs right now against hand-computed literals.
  task automatic checkOutput(input string name, input logic [W-1:0] expSum,
                             input logic expCarry);
    checks++;
    if (outSumResult !== expSum || outCarry !== expCarry) begin
      errors++;
      $display("[TB] FAIL %s: got sum=%h carry=%b, expected sum=%h carry=%b",
               name, outSumResult, outCarry, expSum, expCarry);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   golden;

    // Reset with all-ones inputs; outputs must read zero before any clock edge.
    enable = 1'b0;
    inSumA = 32'hFFFF_FFFF;
    inSumB = 32'hFFFF_FFFF;
    #2;
    checkOutput("reset_no_clk", 32'h0000_0000, 1'b0);
    compareOn = 1'b1;
    waitCycles(3);
    checkOutput("reset_held", 32'h0000_0000, 1'b0);

    // Release reset between edges.
    enable = 1'b1;

    // Basic addition, two edges of latency.
    applyStimulus(32'h0000_0005, 32'h0000_0003);
    waitCycles(2);
    checkOutput("basic_5_3", 32'h0000_0008, 1'b0);

    // Carry ripples through every bit.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001);
    waitCycles(2);
    checkOutput("full_ripple", 32'h0000_0000, 1'b1);

    // Largest operands.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitCycles(2);
    checkOutput("max_operands", 32'hFFFF_FFFE, 1'b1);

    // Alternating bit patterns, no carries anywhere.
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555);
    waitCycles(2);
    checkOutput("alt_bits", 32'hFFFF_FFFF, 1'b0);

    // Back-to-back pairs, one result per cycle.
    applyStimulus(32'h0000_0001, 32'h0000_0002);
    applyStimulus(32'h0000_0003, 32'h0000_0004);
    applyStimulus(32'h8000_0000, 32'h8000_0000);
    checkOutput("pipe_1_2", 32'h0000_0003, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0000);
    checkOutput("pipe_3_4", 32'h0000_0007, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0000);
    checkOutput("pipe_msb", 32'h0000_0000, 1'b1);
    waitCycles(1);
    checkOutput("pipe_zero", 32'h0000_0000, 1'b0);

    // Random pairs held for two cycles, checked against 33-bit arithmetic.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      golden = {1'b0, ra} + {1'b0, rb};
      applyStimulus(ra, rb);
      waitCycles(2);
      checkOutput($sformatf("rand_%0d", i), golden[W-1:0], golden[W]);
    end

    // Reset mid-stream with an operation in flight: outputs clear at once.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0002);
    waitCycles(1);
    #2;
    enable = 1'b0;
    #1;
    checkOutput("reset_mid_stream", 32'h0000_0000, 1'b0);
    waitCycles(2);
    checkOutput("reset_mid_held", 32'h0000_0000, 1'b0);

    // After release, the first sample appears on the second rising edge and
    // nothing from before reset resurfaces.
    inSumA = 32'h0000_0010;
    inSumB = 32'h0000_0020;
    enable = 1'b1;
    waitCycles(1);
    checkOutput("post_reset_first_edge", 32'h0000_0000, 1'b0);
    waitCycles(1);
    checkOutput("post_reset_second_edge", 32'h0000_0030, 1'b0);

    waitCycles(2);
    compareOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_adder
